bs_design: RTL and testbench

BS_DESIGN -- requirements
Module: bs_design

---
 rtl/bs_pkg.sv | 6 +
 rtl/bs_stage.sv | 18 +
 rtl/bs_design.sv | 28 ++
 tb/tb_bs_design.sv | 89 ++++++++
 4 files changed

// File: rtl/bs_pkg.sv
// bs_pkg: shared width constants and data type for the barrel shifter
package bs_pkg;
    localparam int BS_WIDTH = 8;
    localparam int BS_SHW = $clog2(BS_WIDTH);
    typedef logic [BS_WIDTH-1:0] bs_data_t;
endpackage

// File: rtl/bs_stage.sv
// bs_stage: one barrel stage, shifts (or rotates with BS_ROTATE_EN) left by DIST when en
module bs_stage #(
    parameter int WIDTH = 8,
    parameter int DIST = 1
) (
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    output logic [WIDTH-1:0] dout
);
    // select moved or untouched data for this stage
    always_comb begin
`ifdef BS_ROTATE_EN
        dout = en ? {din[WIDTH-DIST-1:0], din[WIDTH-1:WIDTH-DIST]} : din;
`else
        dout = en ? din << DIST : din;
`endif
    end
endmodule

// File: rtl/bs_design.sv
// bs_design: log-depth left barrel shifter with registered output; BS_ROTATE_EN selects rotate
module bs_design
    import bs_pkg::*;
#(
    parameter int WIDTH = BS_WIDTH,
    parameter int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [SHW-1:0]   S,
    output logic [WIDTH-1:0] Vout
);
    logic [WIDTH-1:0] stg [SHW+1];
    assign stg[0] = A;
    for (genvar k = 0; k < SHW; k++) begin : g_stage
        bs_stage #(.WIDTH(WIDTH), .DIST(1 << k)) u_stage (
            .din (stg[k]),
            .en  (S[k]),
            .dout(stg[k+1])
        );
    end
    // capture the final stage; reset forces zeros regardless of A/S
    always_ff @(posedge clk) begin
        if (rst) Vout <= '0;
        else Vout <= stg[SHW];
    end
endmodule

// File: tb/tb_bs_design.sv
// tb_bs_design: directed and random checks of bs_design (default or BS_ROTATE_EN build)
module tb_bs_design;
    import bs_pkg::*;
    logic clk = 0;
    logic rst = 1;
    bs_data_t A = '0;
    logic [BS_SHW-1:0] S = '0;
    bs_data_t Vout;
    int total = 0;
    int bad = 0;

    bs_design dut (.clk(clk), .rst(rst), .A(A), .S(S), .Vout(Vout));

    always #5 clk = ~clk;

    function automatic bs_data_t ref_f(input bs_data_t a, input int s);
        bs_data_t r;
        r = a;
        for (int i = 0; i < s; i++)
`ifdef BS_ROTATE_EN
            r = {r[BS_WIDTH-2:0], r[BS_WIDTH-1]};
`else
            r = {r[BS_WIDTH-2:0], 1'b0};
`endif
        return r;
    endfunction

    task automatic step(input bs_data_t a, input int s, input logic r);
        @(negedge clk);
        A = a;
        S = s[BS_SHW-1:0];
        rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input bs_data_t got, input bs_data_t exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    bs_data_t ta [8] = '{8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hFF};
    int ts [8] = '{0, 1, 2, 4, 5, 6, 7, 3};
`ifdef BS_ROTATE_EN
    bs_data_t te [8] = '{8'hCC, 8'h99, 8'h33, 8'hCC, 8'h99, 8'h33, 8'h66, 8'hFF};
    bs_data_t rel_exp = 8'hFF;
`else
    bs_data_t te [8] = '{8'hCC, 8'h98, 8'h30, 8'hC0, 8'h80, 8'h00, 8'h00, 8'hF8};
    bs_data_t rel_exp = 8'hF8;
`endif

    initial begin
        bs_data_t a;
        int s;
        logic r;
        step(8'hFF, 3, 1);
        chk("reset1", Vout, 8'h00);
        step(8'hFF, 3, 1);
        chk("reset2", Vout, 8'h00);
        step('x, 'x, 1);
        chk("reset_x", Vout, 8'h00);
        step(8'hFF, 3, 0);
        chk("release", Vout, rel_exp);
        for (int i = 0; i < 8; i++) begin
            step(ta[i], ts[i], 0);
            chk($sformatf("dir%0d", i), Vout, te[i]);
        end
        for (int i = 0; i < 8; i++) begin
            step(8'h01, i, 0);
            chk($sformatf("b2b%0d", i), Vout, 8'(1 << i));
        end
        step(8'hA5, 3, 1);
        chk("mid_rst", Vout, 8'h00);
        step(8'h81, 1, 0);
        chk("post_rst", Vout, ref_f(8'h81, 1));
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom);
            s = $urandom_range(0, BS_WIDTH - 1);
            r = ($urandom_range(0, 19) == 0);
            step(a, s, r);
            chk("rand", Vout, r ? 8'h00 : ref_f(a, s));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
